// File: rtl/ad_pkg.sv
// Shared constants and FSM state encodings for the adaptive-array coefficient loader.
package ad_pkg;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int N_COE = 16;

    localparam logic [1:0] ST_COLLECT   = 2'd0;
    localparam logic [1:0] ST_DRAIN     = 2'd1;
    localparam logic [1:0] ST_WAIT_SYNC = 2'd2;
    localparam logic [1:0] ST_COMMIT    = 2'd3;

    function automatic logic state_busy(input logic [1:0] s);
        return (s == ST_WAIT_SYNC) || (s == ST_COMMIT);
    endfunction

endpackage

// File: rtl/ad_coe_stage.sv
// Staging register file for one coefficient set: one write port, one asynchronous read port.
module ad_coe_stage #(
    parameter int DW    = ad_pkg::DW,
    parameter int AW    = ad_pkg::AW,
    parameter int N_COE = ad_pkg::N_COE
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_widx,
    input  logic [2*DW-1:0]   i_wdata,
    input  logic [AW-1:0]     i_ridx,
    output logic [2*DW-1:0]   o_rdata
);
    import ad_pkg::*;

    logic [2*DW-1:0] r_mem [N_COE];

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_widx] <= i_wdata;
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/ad_coe_loader.sv
// Coefficient RAM writer: stages a full weight set, then bursts it to the RAM on frame_sync.
// Define AD_COE_CONJ_EN to write conjugated (saturating negated imaginary) weights.
module ad_coe_loader #(
    parameter int DW    = ad_pkg::DW,
    parameter int AW    = ad_pkg::AW,
    parameter int N_COE = ad_pkg::N_COE
) (
    input  logic          clk_61p44MHz,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_last,
    input  logic [DW-1:0] s_coe_r,
    input  logic [DW-1:0] s_coe_i,
    input  logic          frame_sync,
    output logic [AW-1:0] address,
    output logic          we_coe,
    output logic [DW-1:0] coe_r,
    output logic [DW-1:0] coe_i,
    output logic          busy,
    output logic          set_done,
    output logic          err_len
);
    import ad_pkg::*;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_COE - 1);

    logic [1:0]      r_state;
    logic [AW-1:0]   r_idx;
    logic            r_rdy_en;
    logic [AW-1:0]   r_address;
    logic            r_we_coe;
    logic [DW-1:0]   r_coe_r;
    logic [DW-1:0]   r_coe_i;
    logic            r_set_done;
    logic            r_err_len;

    logic            w_accept;
    logic            w_stage_we;
    logic [AW-1:0]   w_ridx;
    logic [2*DW-1:0] w_rdata;
    logic [DW-1:0]   w_rd_r;
    logic [DW-1:0]   w_rd_i;
    logic [DW-1:0]   w_out_i;

    // r_rdy_en keeps s_ready low while reset is held, then rises on the first clock.
    assign s_ready    = r_rdy_en && ((r_state == ST_COLLECT) || (r_state == ST_DRAIN));
    assign w_accept   = s_valid && s_ready;
    assign w_stage_we = w_accept && (r_state == ST_COLLECT);
    assign w_ridx     = (r_state == ST_COMMIT) ? AW'(r_address + 1'b1) : '0;

    ad_coe_stage #(
        .DW    (DW),
        .AW    (AW),
        .N_COE (N_COE)
    ) u_stage (
        .i_clk   (clk_61p44MHz),
        .i_we    (w_stage_we),
        .i_widx  (r_idx),
        .i_wdata ({s_coe_r, s_coe_i}),
        .i_ridx  (w_ridx),
        .o_rdata (w_rdata)
    );

    assign w_rd_r = w_rdata[2*DW-1:DW];
    assign w_rd_i = w_rdata[DW-1:0];

`ifdef AD_COE_CONJ_EN
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
    assign w_out_i = (w_rd_i == MIN_NEG) ? MAX_POS : DW'(~w_rd_i + 1'b1);
`else
    assign w_out_i = w_rd_i;
`endif

    always_ff @(posedge clk_61p44MHz or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_COLLECT;
            r_idx      <= '0;
            r_rdy_en   <= 1'b0;
            r_address  <= '0;
            r_we_coe   <= 1'b0;
            r_coe_r    <= '0;
            r_coe_i    <= '0;
            r_set_done <= 1'b0;
            r_err_len  <= 1'b0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_we_coe   <= 1'b0;
            r_set_done <= 1'b0;
            r_err_len  <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
                            if (s_last) begin
                                r_state <= ST_WAIT_SYNC;
                            end else begin
                                r_err_len <= 1'b1;
                                r_state   <= ST_DRAIN;
                            end
                        end else if (s_last) begin
                            r_err_len <= 1'b1;
                            r_idx     <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_accept && s_last)
                        r_state <= ST_COLLECT;
                end
                // Word 0 is launched on the frame_sync edge so the burst starts one cycle later.
                ST_WAIT_SYNC: begin
                    if (frame_sync) begin
                        r_state   <= ST_COMMIT;
                        r_we_coe  <= 1'b1;
                        r_address <= w_ridx;
                        r_coe_r   <= w_rd_r;
                        r_coe_i   <= w_out_i;
                    end
                end
                ST_COMMIT: begin
                    if (r_address == LAST_IDX) begin
                        r_set_done <= 1'b1;
                        r_state    <= ST_COLLECT;
                    end else begin
                        r_we_coe  <= 1'b1;
                        r_address <= w_ridx;
                        r_coe_r   <= w_rd_r;
                        r_coe_i   <= w_out_i;
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

    assign address  = r_address;
    assign we_coe   = r_we_coe;
    assign coe_r    = r_coe_r;
    assign coe_i    = r_coe_i;
    assign busy     = state_busy(r_state);
    assign set_done = r_set_done;
    assign err_len  = r_err_len;

endmodule
